// File: rtl/spiflash_resp.sv
`default_nettype none
// spiflash_resp: SPI flash read responder (0x03, mode 0) bridging to a byte-wide memory request port. Rev 1.0
// Optional: define SPIFLASH_RESP_FASTREAD_EN to accept 0x0B fast read with 8 dummy clocks.
module spiflash_resp (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flash_csb,
  input  logic        flash_clk,
  input  logic        flash_io0_di,
  output logic        flash_io1_do,
  output logic        flash_io1_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0] OP_READ = 8'h03;
`ifdef SPIFLASH_RESP_FASTREAD_EN
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  // Synchronizer bit order: {csb, sck, mosi}
  logic [2:0]  in_meta_q, in_meta_d;
  logic [2:0]  in_sync_q, in_sync_d;
  logic [1:0]  edge_prev_q, edge_prev_d;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [7:0]  prefetch_q, prefetch_d;
  logic        do_q, do_d;
  logic        oe_q, oe_d;
  logic        mem_valid_q, mem_valid_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic        discard_q, discard_d;
`ifdef SPIFLASH_RESP_FASTREAD_EN
  logic        fast_q, fast_d;
`endif

  logic        csb_rise, csb_fall, sck_rise, sck_fall, mosi_s;
  logic [7:0]  opcode;
  logic [23:0] rx_addr;
  logic        issue_req;
  logic [23:0] req_addr;

  assign csb_rise = in_sync_q[2] & ~edge_prev_q[1];
  assign csb_fall = ~in_sync_q[2] & edge_prev_q[1];
  assign sck_rise = in_sync_q[1] & ~edge_prev_q[0];
  assign sck_fall = ~in_sync_q[1] & edge_prev_q[0];
  assign mosi_s   = in_sync_q[0];
  assign opcode   = {shift_in_q[6:0], mosi_s};
  assign rx_addr  = {shift_in_q, mosi_s};

  always_comb begin
    in_meta_d   = {flash_csb, flash_clk, flash_io0_di};
    in_sync_d   = in_meta_q;
    edge_prev_d = in_sync_q[2:1];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    prefetch_d  = prefetch_q;
    do_d        = do_q;
    oe_d        = oe_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    discard_d   = discard_q;
    issue_req   = 1'b0;
    req_addr    = mem_addr_q;
`ifdef SPIFLASH_RESP_FASTREAD_EN
    fast_d      = fast_q;
`endif

    // A request aborted by csb still completes; its data is dropped.
    if (mem_valid_q && mem_ready) begin
      mem_valid_d = 1'b0;
      discard_d   = 1'b0;
      if (!discard_q) prefetch_d = mem_rdata;
    end

    if (csb_rise) begin
      state_d   = ST_IDLE;
      oe_d      = 1'b0;
      bit_cnt_d = 5'd0;
      if (mem_valid_q && !mem_ready) discard_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csb_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 5'd0;
`ifdef SPIFLASH_RESP_FASTREAD_EN
            fast_d    = 1'b0;
`endif
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            shift_in_d = {shift_in_q[21:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if (opcode == OP_READ) state_d = ST_ADDR;
`ifdef SPIFLASH_RESP_FASTREAD_EN
              else if (opcode == OP_FAST_READ) begin
                state_d = ST_ADDR;
                fast_d  = 1'b1;
              end
`endif
              else state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            shift_in_d = {shift_in_q[21:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = 5'd0;
              issue_req = 1'b1;
              req_addr  = rx_addr;
`ifdef SPIFLASH_RESP_FASTREAD_EN
              state_d   = fast_q ? ST_DUMMY : ST_DATA;
`else
              state_d   = ST_DATA;
`endif
            end
          end
        end
`ifdef SPIFLASH_RESP_FASTREAD_EN
        ST_DUMMY: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              state_d   = ST_DATA;
            end
          end
        end
`endif
        ST_DATA: begin
          // The first falling edge of each byte takes the prefetched byte and requests the next one.
          if (sck_fall) begin
            oe_d      = 1'b1;
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd0) begin
              do_d        = prefetch_q[7];
              shift_out_d = {prefetch_q[6:0], 1'b0};
              issue_req   = 1'b1;
              req_addr    = mem_addr_q + 24'd1;
            end else begin
              do_d        = shift_out_q[7];
              shift_out_d = {shift_out_q[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end

    if (issue_req) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = req_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_meta_q   <= 3'b100;
      in_sync_q   <= 3'b100;
      edge_prev_q <= 2'b10;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_in_q  <= 23'd0;
      shift_out_q <= 8'd0;
      prefetch_q  <= 8'd0;
      do_q        <= 1'b0;
      oe_q        <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 24'd0;
      discard_q   <= 1'b0;
`ifdef SPIFLASH_RESP_FASTREAD_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      in_meta_q   <= in_meta_d;
      in_sync_q   <= in_sync_d;
      edge_prev_q <= edge_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      prefetch_q  <= prefetch_d;
      do_q        <= do_d;
      oe_q        <= oe_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      discard_q   <= discard_d;
`ifdef SPIFLASH_RESP_FASTREAD_EN
      fast_q      <= fast_d;
`endif
    end
  end

  assign flash_io1_do = do_q;
  assign flash_io1_oe = oe_q;
  assign mem_valid    = mem_valid_q;
  assign mem_addr     = mem_addr_q;

endmodule
`default_nettype wire
